// File: rtl/mother_board_param.sv
`default_nettype none
// ============================================================================
// Module   : mother_board_param
// Brief    : Board-level accumulator CPU with program ROM, carry flag, latched
//            output port and a step prescaler that paces execution.
// Revision : 1.0 - initial release
// ============================================================================
module mother_board_param #(
  parameter int DW = 4,
  parameter int AW = 4,
  parameter int PRESCALE = 0,
  parameter bit USE_ROM_IMAGE = 1'b0,
  parameter logic [(2**AW)*(DW+3)-1:0] ROM_IMAGE = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  output logic [DW-1:0] out_port,
  output logic          led,
  output logic [AW-1:0] pc,
  output logic          halted
);

  localparam int IW = DW + 3;
  localparam int PW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;

  localparam logic [2:0] c_op_nop  = 3'b000;
  localparam logic [2:0] c_op_not  = 3'b001;
  localparam logic [2:0] c_op_ld   = 3'b010;
  localparam logic [2:0] c_op_add  = 3'b011;
  localparam logic [2:0] c_op_out  = 3'b100;
  localparam logic [2:0] c_op_jmp  = 3'b101;
  localparam logic [2:0] c_op_jnc  = 3'b110;
  localparam logic [2:0] c_op_halt = 3'b111;

  localparam logic [PW-1:0] c_presc_max = PW'(PRESCALE);

  logic [PW-1:0] r_presc;
  logic [AW-1:0] r_pc;
  logic [DW-1:0] r_acc;
  logic [DW-1:0] r_out;
  logic          r_carry;
  logic          r_halted;

  logic [IW-1:0] w_instr;
  logic [2:0]    w_op;
  logic [DW-1:0] w_imm;
  logic [AW-1:0] w_target;
  logic [AW-1:0] w_pc_inc;
  logic [DW:0]   w_sum;
  logic          w_step;

  // Either a caller-supplied flat image (entry i at bits [i*IW +: IW]) or the
  // built-in count-up demo program.
  generate
    if (USE_ROM_IMAGE) begin : g_rom_image
      assign w_instr = ROM_IMAGE[int'(r_pc)*IW +: IW];
    end else begin : g_rom_default
      always_comb begin
        w_instr = '0;
        case (int'(r_pc))
          0:       w_instr = {c_op_ld,   DW'(0)};
          1:       w_instr = {c_op_add,  DW'(1)};
          2:       w_instr = {c_op_out,  DW'(0)};
          3:       w_instr = {c_op_jnc,  DW'(1)};
          4:       w_instr = {c_op_not,  DW'(0)};
          5:       w_instr = {c_op_out,  DW'(0)};
          6:       w_instr = {c_op_halt, DW'(0)};
          default: w_instr = {c_op_nop,  DW'(0)};
        endcase
      end
    end
  endgenerate

  assign w_op     = w_instr[IW-1 -: 3];
  assign w_imm    = w_instr[DW-1:0];
  assign w_target = AW'(w_imm);
  assign w_pc_inc = r_pc + AW'(1);
  assign w_sum    = {1'b0, r_acc} + {1'b0, w_imm};
  assign w_step   = run && !r_halted && (r_presc == c_presc_max);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc  <= '0;
      r_pc     <= '0;
      r_acc    <= '0;
      r_out    <= '0;
      r_carry  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      if (!run) begin
        r_presc <= '0;
      end else if (!r_halted) begin
        r_presc <= (r_presc == c_presc_max) ? '0 : r_presc + PW'(1);
      end

      if (w_step) begin
        r_pc <= w_pc_inc;
        case (w_op)
          c_op_not: r_acc <= ~r_acc;
          c_op_ld: begin
            r_acc   <= w_imm;
            r_carry <= 1'b0;
          end
          c_op_add: {r_carry, r_acc} <= w_sum;
          c_op_out: r_out <= r_acc;
          c_op_jmp: r_pc <= w_target;
          c_op_jnc: if (!r_carry) r_pc <= w_target;
          c_op_halt: begin
            r_halted <= 1'b1;
            r_pc     <= r_pc;
          end
          default: ;
        endcase
      end
    end
  end

  assign out_port = r_out;
  assign led      = r_out[0];
  assign pc       = r_pc;
  assign halted   = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_mother_board_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_mother_board_param
// Brief    : Self-checking bench: vector table, hand sequences and a random
//            run-pattern run against an instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mother_board_param;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic run0 = 1'b0, run3 = 1'b0, runc = 1'b0;

  logic [3:0] out0, out3, outc;
  logic [3:0] pc0, pc3, pcc;
  logic       led0, led3, ledc;
  logic       h0, h3, hc;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Custom image: 0 ADD 1 | 1 JNC 5 | 2 LD A | 3 OUT | 4 HALT | 5 LD F | 6 JMP F | F NOP
  localparam logic [16*7-1:0] c_rom_custom = {
    {9{7'b000_0000}},
    {3'b101, 4'hF}, {3'b010, 4'hF}, {3'b111, 4'h0}, {3'b100, 4'h0},
    {3'b010, 4'hA}, {3'b110, 4'h5}, {3'b011, 4'h1}
  };

  always #5 clk = ~clk;

  mother_board_param #(.DW(4), .AW(4), .PRESCALE(0)) dut0 (
    .clk(clk), .reset(reset), .run(run0),
    .out_port(out0), .led(led0), .pc(pc0), .halted(h0)
  );

  mother_board_param #(.DW(4), .AW(4), .PRESCALE(3)) dut3 (
    .clk(clk), .reset(reset), .run(run3),
    .out_port(out3), .led(led3), .pc(pc3), .halted(h3)
  );

  mother_board_param #(.DW(4), .AW(4), .PRESCALE(0), .USE_ROM_IMAGE(1'b1),
                       .ROM_IMAGE(c_rom_custom)) dutc (
    .clk(clk), .reset(reset), .run(runc),
    .out_port(outc), .led(ledc), .pc(pcc), .halted(hc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
  endtask

  // ---------------- instruction-level reference model -----------------------
  typedef struct {
    int acc; int carry; int pc; int outp; int halted; int streak;
  } model_t;

  int rom_op[16];
  int rom_imm[16];

  function automatic model_t model_init();
    model_t m;
    m.acc = 0; m.carry = 0; m.pc = 0; m.outp = 0; m.halted = 0; m.streak = 0;
    return m;
  endfunction

  function automatic model_t model_exec(model_t m);
    int op, imm, next, s;
    op = rom_op[m.pc];
    imm = rom_imm[m.pc];
    next = (m.pc + 1) % 16;
    case (op)
      1: m.acc = 15 - m.acc;
      2: begin m.acc = imm; m.carry = 0; end
      3: begin s = m.acc + imm; m.carry = (s > 15) ? 1 : 0; m.acc = s % 16; end
      4: m.outp = m.acc;
      5: next = imm;
      6: if (m.carry == 0) next = imm;
      7: begin m.halted = 1; next = m.pc; end
      default: ;
    endcase
    m.pc = next;
    return m;
  endfunction

  // One clock edge with the given run level: a step fires once run has been
  // high for PRESCALE+1 consecutive cycles.
  function automatic model_t model_edge(model_t m, int run_v, int presc);
    if (run_v == 0) begin
      m.streak = 0;
    end else if (m.halted == 0) begin
      m.streak++;
      if (m.streak == presc + 1) begin
        m.streak = 0;
        m = model_exec(m);
      end
    end
    return m;
  endfunction

  typedef struct {
    int         cyc;
    int         sel;
    logic [3:0] out;
    logic [3:0] pc;
    logic       halted;
  } vec_t;

  vec_t vecs[$];
  model_t m0, m3;

  initial begin
    // default program as ISA table
    for (int i = 0; i < 16; i++) begin rom_op[i] = 0; rom_imm[i] = 0; end
    rom_op[0] = 2; rom_imm[0] = 0;
    rom_op[1] = 3; rom_imm[1] = 1;
    rom_op[2] = 4;
    rom_op[3] = 6; rom_imm[3] = 1;
    rom_op[4] = 1;
    rom_op[5] = 4;
    rom_op[6] = 7;

    // ---- full program on PRESCALE=0 and PRESCALE=3 boards ----
    vecs = '{
      '{0,  0, 4'h0, 4'h0, 1'b0}, '{0,  1, 4'h0, 4'h0, 1'b0},
      '{2,  0, 4'h0, 4'h2, 1'b0}, '{3,  0, 4'h1, 4'h3, 1'b0},
      '{3,  1, 4'h0, 4'h0, 1'b0}, '{4,  1, 4'h0, 4'h1, 1'b0},
      '{11, 1, 4'h0, 4'h2, 1'b0}, '{12, 1, 4'h1, 4'h3, 1'b0},
      '{45, 0, 4'hF, 4'h3, 1'b0}, '{48, 0, 4'h0, 4'h3, 1'b0},
      '{51, 0, 4'hF, 4'h6, 1'b0}, '{52, 0, 4'hF, 4'h6, 1'b1},
      '{72, 0, 4'hF, 4'h6, 1'b1}
    };
    #2;
    do_reset();
    run0 = 1'b1; run3 = 1'b1;
    foreach (vecs[i]) begin
      while (cyc < vecs[i].cyc) tick();
      if (vecs[i].sel == 0) begin
        check($sformatf("vec%0d out", i), 32'(out0), 32'(vecs[i].out));
        check($sformatf("vec%0d led", i), 32'(led0), 32'(vecs[i].out[0]));
        check($sformatf("vec%0d pc", i), 32'(pc0), 32'(vecs[i].pc));
        check($sformatf("vec%0d halted", i), 32'(h0), 32'(vecs[i].halted));
      end else begin
        check($sformatf("vec%0d p3 out", i), 32'(out3), 32'(vecs[i].out));
        check($sformatf("vec%0d p3 pc", i), 32'(pc3), 32'(vecs[i].pc));
        check($sformatf("vec%0d p3 halted", i), 32'(h3), 32'(vecs[i].halted));
      end
    end

    // ---- run=0 during edges 10..19 ----
    do_reset();
    run0 = 1'b1; run3 = 1'b0;
    repeat (9) tick();
    check("freeze pre pc", 32'(pc0), 32'h3);
    check("freeze pre out", 32'(out0), 32'h3);
    run0 = 1'b0;
    repeat (10) tick();
    check("freeze hold pc", 32'(pc0), 32'h3);
    check("freeze hold out", 32'(out0), 32'h3);
    run0 = 1'b1;
    tick();
    check("freeze resume pc", 32'(pc0), 32'h1);
    while (cyc < 58) tick();
    check("freeze out@58", 32'(out0), 32'h0);
    while (cyc < 61) tick();
    check("freeze out@61", 32'(out0), 32'hF);
    check("freeze halted@61", 32'(h0), 32'h0);
    tick();
    check("freeze halted@62", 32'(h0), 32'h1);
    check("freeze pc@62", 32'(pc0), 32'h6);

    // ---- asynchronous reset mid-loop ----
    do_reset();
    run0 = 1'b1;
    repeat (22) tick();
    check("async pre out", 32'(out0), 32'h7);
    check("async pre pc", 32'(pc0), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("async out", 32'(out0), 32'h0);
    check("async led", 32'(led0), 32'h0);
    check("async pc", 32'(pc0), 32'h0);
    check("async halted", 32'(h0), 32'h0);
    #1 reset = 1'b0;
    cyc = 0;
    repeat (2) tick();
    check("async restart out@2", 32'(out0), 32'h0);
    tick();
    check("async restart out@3", 32'(out0), 32'h1);

    // ---- custom ROM: jump to last address, wrap, carry fall-through ----
    run0 = 1'b0;
    do_reset();
    runc = 1'b1;
    repeat (4) tick();
    check("custom jmp pc", 32'(pcc), 32'hF);
    tick();
    check("custom wrap pc", 32'(pcc), 32'h0);
    repeat (2) tick();
    check("custom jnc fall pc", 32'(pcc), 32'h2);
    repeat (2) tick();
    check("custom out", 32'(outc), 32'hA);
    check("custom led", 32'(ledc), 32'h0);
    tick();
    check("custom halted", 32'(hc), 32'h1);
    check("custom halt pc", 32'(pcc), 32'h4);
    runc = 1'b0;

    // ---- random run pattern against the reference model ----
    do_reset();
    m0 = model_init();
    m3 = model_init();
    for (int i = 0; i < 400; i++) begin
      int r0, r3;
      r0 = ($urandom_range(0, 3) != 0) ? 1 : 0;
      r3 = ($urandom_range(0, 7) != 0) ? 1 : 0;
      run0 = r0[0];
      run3 = r3[0];
      tick();
      m0 = model_edge(m0, r0, 0);
      m3 = model_edge(m3, r3, 3);
      check("rand p0 pc", 32'(pc0), 32'(m0.pc));
      check("rand p0 out", 32'(out0), 32'(m0.outp));
      check("rand p0 halted", 32'(h0), 32'(m0.halted));
      check("rand p3 pc", 32'(pc3), 32'(m3.pc));
      check("rand p3 out", 32'(out3), 32'(m3.outp));
      check("rand p3 halted", 32'(h3), 32'(m3.halted));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
